mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 158 +++++++++++++++
 tb/tb_mem_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Dual-port word memory responder: instruction port (a) and data port (b)
// share one storage array behind a round-robin, fixed-latency access FSM.
module mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmem_read_a,
    input  logic        cmem_write_a,
    input  logic [31:0] cmem_address_a,
    input  logic [31:0] cmem_wdata_a,
    input  logic [3:0]  cmem_byte_enable_a,
    output logic        cmem_resp_a,
    output logic [31:0] cmem_rdata_a,
    input  logic        cmem_read_b,
    input  logic        cmem_write_b,
    input  logic [31:0] cmem_address_b,
    input  logic [31:0] cmem_wdata_b,
    input  logic [3:0]  cmem_byte_enable_b,
    output logic        cmem_resp_b,
    output logic [31:0] cmem_rdata_b
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          preferB_q;
    logic          portB_q;
    logic          wr_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          resp_a_q;
    logic          resp_b_q;
    logic [31:0]   rdata_a_q;
    logic [31:0]   rdata_b_q;
    logic [31:0]   mem_q [DEPTH_WORDS];

    logic          reqA;
    logic          reqB;
    logic          capture;
    logic          selB;
    logic [31:0]   inAddr;
    logic          enterResp;
    logic          effB;
    logic          effWr;
    logic [AW-1:0] effIdx;
    logic [31:0]   effWdata;
    logic [3:0]    effBe;
    logic          unusedAddrBits;

    // A lone requester always wins; on a tie the port not served last goes.
    assign reqA    = cmem_read_a | cmem_write_a;
    assign reqB    = cmem_read_b | cmem_write_b;
    assign capture = (state_q == IDLE) && (reqA || reqB);
    assign selB    = reqB && (!reqA || preferB_q);
    assign inAddr  = selB ? cmem_address_b : cmem_address_a;

    assign enterResp = (capture && (LATENCY == 1)) ||
                       ((state_q == WAIT) && (cnt_q == '0));

    assign unusedAddrBits = ^{cmem_address_a[31:AW+2], cmem_address_a[1:0],
                              cmem_address_b[31:AW+2], cmem_address_b[1:0]};

    // With LATENCY of 1 the commit happens on the capture edge itself, so the
    // access fields come straight from the selected port instead of the latches.
    always_comb begin
        effB     = portB_q;
        effWr    = wr_q;
        effIdx   = idx_q;
        effWdata = wdata_q;
        effBe    = be_q;
        if (state_q == IDLE) begin
            effB     = selB;
            effWr    = selB ? cmem_write_b : cmem_write_a;
            effIdx   = inAddr[AW+1:2];
            effWdata = selB ? cmem_wdata_b : cmem_wdata_a;
            effBe    = selB ? cmem_byte_enable_b : cmem_byte_enable_a;
        end
    end

    // Storage is never reset; a reset edge suppresses any pending commit.
    always_ff @(posedge clk) begin
        if (!rst && enterResp && effWr) begin
            for (int i = 0; i < 4; i++) begin
                if (effBe[i]) begin
                    mem_q[effIdx][8*i +: 8] <= effWdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            preferB_q <= 1'b1;
            portB_q   <= 1'b0;
            wr_q      <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            resp_a_q  <= 1'b0;
            resp_b_q  <= 1'b0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        portB_q   <= selB;
                        wr_q      <= selB ? cmem_write_b : cmem_write_a;
                        idx_q     <= inAddr[AW+1:2];
                        wdata_q   <= selB ? cmem_wdata_b : cmem_wdata_a;
                        be_q      <= selB ? cmem_byte_enable_b : cmem_byte_enable_a;
                        preferB_q <= ~selB;
                        cnt_q     <= CW'(LATENCY - 1);
                        state_q   <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                RESP: begin
                    state_q  <= IDLE;
                    resp_a_q <= 1'b0;
                    resp_b_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
            // Writes leave read data untouched on both ports.
            if (enterResp) begin
                state_q  <= RESP;
                resp_a_q <= ~effB;
                resp_b_q <= effB;
                if (!effWr) begin
                    if (effB) begin
                        rdata_b_q <= mem_q[effIdx];
                    end else begin
                        rdata_a_q <= mem_q[effIdx];
                    end
                end
            end
        end
    end

    assign cmem_resp_a  = resp_a_q;
    assign cmem_resp_b  = resp_b_q;
    assign cmem_rdata_a = rdata_a_q;
    assign cmem_rdata_b = rdata_b_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder (LATENCY=2, DEPTH_WORDS=256): directed scenarios then
// randomized single/dual-port traffic against a word-level reference model.
module tb_mem_responder;
    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmem_read_a = 1'b0;
    logic        cmem_write_a = 1'b0;
    logic [31:0] cmem_address_a = '0;
    logic [31:0] cmem_wdata_a = '0;
    logic [3:0]  cmem_byte_enable_a = '0;
    logic        cmem_resp_a;
    logic [31:0] cmem_rdata_a;
    logic        cmem_read_b = 1'b0;
    logic        cmem_write_b = 1'b0;
    logic [31:0] cmem_address_b = '0;
    logic [31:0] cmem_wdata_b = '0;
    logic [3:0]  cmem_byte_enable_b = '0;
    logic        cmem_resp_b;
    logic [31:0] cmem_rdata_b;

    int          vectorsApplied = 0;
    int          miscompares = 0;
    logic [31:0] modelMem [int];
    logic [31:0] modelRdata [2];
    bit          lastServedB;
    int          pool [4] = '{4, 8, 12, 16};

    mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .cmem_read_a(cmem_read_a), .cmem_write_a(cmem_write_a),
        .cmem_address_a(cmem_address_a), .cmem_wdata_a(cmem_wdata_a),
        .cmem_byte_enable_a(cmem_byte_enable_a),
        .cmem_resp_a(cmem_resp_a), .cmem_rdata_a(cmem_rdata_a),
        .cmem_read_b(cmem_read_b), .cmem_write_b(cmem_write_b),
        .cmem_address_b(cmem_address_b), .cmem_wdata_b(cmem_wdata_b),
        .cmem_byte_enable_b(cmem_byte_enable_b),
        .cmem_resp_b(cmem_resp_b), .cmem_rdata_b(cmem_rdata_b)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectorsApplied++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        vectorsApplied++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    function automatic logic respOf(input bit p);
        return p ? cmem_resp_b : cmem_resp_a;
    endfunction

    function automatic logic [31:0] rdataOf(input bit p);
        return p ? cmem_rdata_b : cmem_rdata_a;
    endfunction

    task automatic driveRequest(input bit p, input req_t r);
        if (p) begin
            cmem_read_b = r.rd; cmem_write_b = r.wr; cmem_address_b = r.addr;
            cmem_wdata_b = r.wdata; cmem_byte_enable_b = r.be;
        end else begin
            cmem_read_a = r.rd; cmem_write_a = r.wr; cmem_address_a = r.addr;
            cmem_wdata_a = r.wdata; cmem_byte_enable_a = r.be;
        end
    endtask

    task automatic dropRequest(input bit p);
        if (p) begin
            cmem_read_b = 1'b0; cmem_write_b = 1'b0;
        end else begin
            cmem_read_a = 1'b0; cmem_write_a = 1'b0;
        end
    endtask

    function automatic req_t mkReq(input bit rd, input bit wr, input logic [31:0] addr,
                                   input logic [31:0] wdata, input logic [3:0] be);
        req_t r;
        r.rd = rd; r.wr = wr; r.addr = addr; r.wdata = wdata; r.be = be;
        return r;
    endfunction

    // Reference: a word array indexed by (addr/4) mod depth; a write wins over a read.
    task automatic modelAccess(input bit p, input req_t r);
        int          idx;
        logic [31:0] word;
        idx = int'((r.addr / 4) % 256);
        if (r.wr) begin
            word = modelMem.exists(idx) ? modelMem[idx] : 32'h0;
            for (int i = 0; i < 4; i++) begin
                if (r.be[i]) word = (word & ~(32'hFF << (8 * i))) | (r.wdata & (32'hFF << (8 * i)));
            end
            modelMem[idx] = word;
        end else begin
            modelRdata[p] = modelMem[idx];
        end
        lastServedB = p;
    endtask

    // One port alone: response expected exactly two edges after capture.
    task automatic applyStimulus(input bit p, input req_t r);
        req_t junk;
        driveRequest(p, r);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (c == 1) begin
                junk = mkReq(r.rd, r.wr, $urandom, $urandom, 4'($urandom));
                driveRequest(p, junk);
            end
            checkBit("resp served", respOf(p), c == 3);
            checkBit("resp other", respOf(!p), 1'b0);
        end
        modelAccess(p, r);
        checkOutput("rdata served", rdataOf(p), modelRdata[p]);
        checkOutput("rdata other", rdataOf(!p), modelRdata[!p]);
        dropRequest(p);
        @(negedge clk);
        checkBit("resp after a", cmem_resp_a, 1'b0);
        checkBit("resp after b", cmem_resp_b, 1'b0);
    endtask

    // Both ports at once: the port not served last goes first, the other waits.
    task automatic applyDual(input req_t ra, input req_t rb);
        req_t r [2];
        bit   first;
        r[0] = ra; r[1] = rb;
        first = !lastServedB;
        driveRequest(1'b0, ra);
        driveRequest(1'b1, rb);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checkBit("dual resp first", respOf(first), c == 3);
            checkBit("dual resp second", respOf(!first), c == 7);
            if (c == 3) begin
                modelAccess(first, r[first]);
                checkOutput("dual rdata first", rdataOf(first), modelRdata[first]);
                dropRequest(first);
            end
            if (c == 7) begin
                modelAccess(!first, r[!first]);
                checkOutput("dual rdata second", rdataOf(!first), modelRdata[!first]);
                dropRequest(!first);
            end
        end
    endtask

    function automatic req_t randReq();
        req_t r;
        r.rd = 1'($urandom);
        r.wr = 1'($urandom);
        if (!r.rd && !r.wr) r.rd = 1'b1;
        r.addr  = ($urandom & 32'hFFFF_FC03) | (32'(pool[$urandom_range(0, 3)]) << 2);
        r.wdata = $urandom;
        r.be    = 4'($urandom);
        return r;
    endfunction

    initial begin
        lastServedB   = 1'b0;
        modelRdata[0] = 32'h0;
        modelRdata[1] = 32'h0;

        @(negedge clk);
        checkBit("reset resp_a", cmem_resp_a, 1'b0);
        checkBit("reset resp_b", cmem_resp_b, 1'b0);
        checkOutput("reset rdata_a", cmem_rdata_a, 32'h0);
        checkOutput("reset rdata_b", cmem_rdata_b, 32'h0);
        rst = 1'b0;

        applyStimulus(1'b1, mkReq(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF));
        applyStimulus(1'b0, mkReq(1'b1, 1'b0, 32'h10, 32'h0, 4'h0));
        checkOutput("deadbeef", cmem_rdata_a, 32'hDEADBEEF);
        applyStimulus(1'b1, mkReq(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0101));
        applyStimulus(1'b0, mkReq(1'b1, 1'b0, 32'h10, 32'h0, 4'h0));
        checkOutput("byte lanes", cmem_rdata_a, 32'hDE22BE44);
        applyStimulus(1'b1, mkReq(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF));
        applyStimulus(1'b0, mkReq(1'b1, 1'b0, 32'h413, 32'h0, 4'h0));
        checkOutput("alias", cmem_rdata_a, 32'hCAFEF00D);
        applyStimulus(1'b0, mkReq(1'b1, 1'b1, 32'h30, 32'hA5A5A5A5, 4'hF));
        applyStimulus(1'b1, mkReq(1'b1, 1'b0, 32'h30, 32'h0, 4'h0));
        checkOutput("rd+wr as write", cmem_rdata_b, 32'hA5A5A5A5);
        applyStimulus(1'b1, mkReq(1'b0, 1'b1, 32'h20, 32'h0, 4'hF));
        applyStimulus(1'b1, mkReq(1'b0, 1'b1, 32'h40, 32'h01020304, 4'hF));

        // Reset lands while the write is still waiting: it must be dropped.
        driveRequest(1'b1, mkReq(1'b0, 1'b1, 32'h20, 32'h12345678, 4'hF));
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkBit("abort resp_a", cmem_resp_a, 1'b0);
        checkBit("abort resp_b", cmem_resp_b, 1'b0);
        checkOutput("abort rdata_a", cmem_rdata_a, 32'h0);
        checkOutput("abort rdata_b", cmem_rdata_b, 32'h0);
        @(negedge clk);
        dropRequest(1'b1);
        rst = 1'b0;
        modelRdata[0] = 32'h0;
        modelRdata[1] = 32'h0;
        lastServedB   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkBit("abort no resp_b", cmem_resp_b, 1'b0);
        end

        applyDual(mkReq(1'b1, 1'b0, 32'h30, 32'h0, 4'h0),
                  mkReq(1'b0, 1'b1, 32'h40, 32'h0BADF00D, 4'hF));
        applyDual(mkReq(1'b0, 1'b1, 32'h40, 32'h55AA55AA, 4'b1001),
                  mkReq(1'b1, 1'b0, 32'h10, 32'h0, 4'h0));
        applyStimulus(1'b0, mkReq(1'b1, 1'b0, 32'h20, 32'h0, 4'h0));
        checkOutput("aborted write", cmem_rdata_a, 32'h0);

        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                applyDual(randReq(), randReq());
            end else begin
                applyStimulus(1'($urandom), randReq());
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end
endmodule
